boa_mem_bus_arb: RTL and testbench

Two-master, one-slave arbiter for the boa memory bus. It lets the program port and the data port of a boa32 core share one memory slave port, such as a single-ported block RAM or a peripheral bus. It routes each request to the slave and steers read data back to the master that issued the read. The bus signal set (re, we mask, word address, wdata, rdata, ready) is the same on all three ports.

---
 rtl/boa_mem_bus_pkg.sv | 25 ++
 rtl/boa_mem_bus_rr.sv | 63 ++++++
 rtl/boa_mem_bus_arb.sv | 83 ++++++++
 tb/tb_boa_mem_bus_arb.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/boa_mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// boa_mem_bus_pkg : shared widths, request type and grant encoding for the
//                   boa memory bus arbiters.          Rev 1.0
// ============================================================================
package boa_mem_bus_pkg;

  localparam int BOA_ADDR_W = 30;
  localparam int BOA_DATA_W = 32;
  localparam int BOA_MASK_W = BOA_DATA_W / 8;

  typedef struct packed {
    logic                  re;
    logic [BOA_MASK_W-1:0] we;
    logic [BOA_ADDR_W-1:0] addr;
    logic [BOA_DATA_W-1:0] wdata;
  } boa_req_t;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } boa_gnt_e;

endpackage
`default_nettype wire

// File: rtl/boa_mem_bus_rr.sv
`default_nettype none
// ============================================================================
// boa_mem_bus_rr : 2-way grant with lock-until-accept; round-robin on
//                  contention when BOA_MEM_BUS_RR_EN is defined.   Rev 1.0
// ============================================================================
module boa_mem_bus_rr
  import boa_mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       gnt_o
);

  logic     lock_q, lock_d;
  boa_gnt_e owner_q, owner_d;
  boa_gnt_e gnt;
  boa_gnt_e contend_winner;

`ifdef BOA_MEM_BUS_RR_EN
  boa_gnt_e ptr_q, ptr_d;

  assign contend_winner = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = (gnt == GNT_M0) ? GNT_M1 : GNT_M0;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= GNT_M0;
    else     ptr_q <= ptr_d;
  end
`else
  assign contend_winner = GNT_M0;
`endif

  // The lock only holds while its owner is still asking, so a misbehaving
  // master that withdraws cannot starve the other one.
  always_comb begin
    gnt = GNT_M0;
    if (lock_q && req_i[owner_q]) gnt = owner_q;
    else if (req_i == 2'b10)      gnt = GNT_M1;
    else if (req_i == 2'b11)      gnt = contend_winner;
    lock_d  = req_i[gnt] && !accept_i;
    owner_d = gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= 1'b0;
      owner_q <= GNT_M0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end

  assign gnt_o = gnt;

endmodule
`default_nettype wire

// File: rtl/boa_mem_bus_arb.sv
`default_nettype none
// ============================================================================
// boa_mem_bus_arb : two-master / one-slave boa memory bus arbiter with read
//                   response steering. Option: BOA_MEM_BUS_RR_EN. Rev 1.0
// ============================================================================
module boa_mem_bus_arb
  import boa_mem_bus_pkg::*;
#(
  parameter int ADDR_W = BOA_ADDR_W,
  parameter int DATA_W = BOA_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_re_i,
  input  logic [DATA_W/8-1:0]   m0_we_i,
  input  logic [ADDR_W-1:0]     m0_addr_i,
  input  logic [DATA_W-1:0]     m0_wdata_i,
  output logic                  m0_ready_o,
  output logic [DATA_W-1:0]     m0_rdata_o,
  input  logic                  m1_re_i,
  input  logic [DATA_W/8-1:0]   m1_we_i,
  input  logic [ADDR_W-1:0]     m1_addr_i,
  input  logic [DATA_W-1:0]     m1_wdata_i,
  output logic                  m1_ready_o,
  output logic [DATA_W-1:0]     m1_rdata_o,
  output logic                  s_re_o,
  output logic [DATA_W/8-1:0]   s_we_o,
  output logic [ADDR_W-1:0]     s_addr_o,
  output logic [DATA_W-1:0]     s_wdata_o,
  input  logic                  s_ready_i,
  input  logic [DATA_W-1:0]     s_rdata_i
);

  logic [1:0] req;
  logic       gnt_m1;
  logic       gnt_req;
  logic       accept;
  logic       resp_vld_q, resp_vld_d;
  logic       resp_sel_q, resp_sel_d;

  assign req[0] = m0_re_i | (|m0_we_i);
  assign req[1] = m1_re_i | (|m1_we_i);

  boa_mem_bus_rr u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .accept_i (accept),
    .gnt_o    (gnt_m1)
  );

  assign gnt_req = gnt_m1 ? req[1] : req[0];
  assign accept  = gnt_req && s_ready_i && !rst;

  // With no request the grant rests on master 0, whose idle re/we are zero.
  assign s_re_o    = gnt_m1 ? m1_re_i    : m0_re_i;
  assign s_we_o    = gnt_m1 ? m1_we_i    : m0_we_i;
  assign s_addr_o  = gnt_m1 ? m1_addr_i  : m0_addr_i;
  assign s_wdata_o = gnt_m1 ? m1_wdata_i : m0_wdata_i;

  assign m0_ready_o = s_ready_i && !gnt_m1 && !rst;
  assign m1_ready_o = s_ready_i &&  gnt_m1 && !rst;

  always_comb begin
    resp_vld_d = accept && s_re_o;
    resp_sel_d = resp_vld_d ? gnt_m1 : resp_sel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_vld_q <= 1'b0;
      resp_sel_q <= GNT_M0;
    end else begin
      resp_vld_q <= resp_vld_d;
      resp_sel_q <= resp_sel_d;
    end
  end

  assign m0_rdata_o = (resp_vld_q && !resp_sel_q && !rst) ? s_rdata_i : '0;
  assign m1_rdata_o = (resp_vld_q &&  resp_sel_q && !rst) ? s_rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_boa_mem_bus_arb.sv
`default_nettype none
// ============================================================================
// tb_boa_mem_bus_arb : directed vectors with a per-cycle expectation queue
//                      drained by an independent monitor.      Rev 1.0
// ============================================================================
module tb_boa_mem_bus_arb;
  import boa_mem_bus_pkg::*;

  localparam logic [29:0] A0 = 30'h400;
  localparam logic [29:0] A1 = 30'h800;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_re, m1_re, m0_ready, m1_ready, s_re, s_ready;
  logic [3:0]  m0_we, m1_we, s_we;
  logic [29:0] m0_addr, m1_addr, s_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;

  always #5 clk = ~clk;

  boa_mem_bus_arb dut (
    .clk(clk), .rst(rst),
    .m0_re_i(m0_re), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_ready_o(m0_ready), .m0_rdata_o(m0_rdata),
    .m1_re_i(m1_re), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_ready_o(m1_ready), .m1_rdata_o(m1_rdata),
    .s_re_o(s_re), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_ready_i(s_ready), .s_rdata_i(s_rdata)
  );

  typedef struct {
    logic        rst;
    logic        m0re;
    logic [3:0]  m0we;
    logic [29:0] m0a;
    logic [31:0] m0d;
    logic        m1re;
    logic [29:0] m1a;
    logic        sr;
    logic [31:0] srd;
  } stim_t;

  typedef struct {
    string       tag;
    logic [1:0]  rdy;
    logic        sre;
    logic [3:0]  swe;
    logic [29:0] saddr;
    logic [31:0] swd;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, ".ready"}, {30'b0, m1_ready, m0_ready}, {30'b0, e.rdy});
      chk({e.tag, ".s_re"},  {31'b0, s_re},  {31'b0, e.sre});
      chk({e.tag, ".s_we"},  {28'b0, s_we},  {28'b0, e.swe});
      chk({e.tag, ".s_addr"}, {2'b0, s_addr}, {2'b0, e.saddr});
      chk({e.tag, ".s_wdata"}, s_wdata, e.swd);
      chk({e.tag, ".m0_rdata"}, m0_rdata, e.rd0);
      chk({e.tag, ".m1_rdata"}, m1_rdata, e.rd1);
    end
  end

  // Master 0 reads A0, master 1 reads A1; idle masters drive zeros.
  function automatic stim_t rd(input logic r, input logic a, input logic b,
                               input logic sr, input logic [31:0] srd);
    stim_t s;
    s.rst = r;  s.m0re = a; s.m0we = 4'b0; s.m0a = a ? A0 : 30'b0; s.m0d = 32'b0;
    s.m1re = b; s.m1a = b ? A1 : 30'b0;   s.sr = sr; s.srd = srd;
    return s;
  endfunction

  task automatic step(input string tag, input stim_t s, input logic [1:0] rdy,
                      input logic sre, input logic [3:0] swe, input logic [29:0] saddr,
                      input logic [31:0] swd, input logic [31:0] rd0, input logic [31:0] rd1);
    exp_t e;
    rst = s.rst; m0_re = s.m0re; m0_we = s.m0we; m0_addr = s.m0a; m0_wdata = s.m0d;
    m1_re = s.m1re; m1_we = 4'b0; m1_addr = s.m1a; m1_wdata = 32'b0;
    s_ready = s.sr; s_rdata = s.srd;
    e.tag = tag; e.rdy = rdy; e.sre = sre; e.swe = swe; e.saddr = saddr;
    e.swd = swd; e.rd0 = rd0; e.rd1 = rd1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t w;
    logic  g, pg;
    rst = 1'b1; m0_re = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_re = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; s_ready = 0; s_rdata = 0;
    @(posedge clk);
    #1;
    step("rst0", rd(1, 0, 0, 0, 0), 2'b00, 0, 0, 0, 0, 0, 0);
    step("rst1", rd(1, 0, 0, 1, 32'hFFFF0000), 2'b00, 0, 0, 0, 0, 0, 0);

    step("t1_req", rd(0, 1, 0, 1, 0), 2'b01, 1, 0, A0, 0, 0, 0);
    step("t1_rsp", rd(0, 0, 0, 0, 32'hDEADBEEF), 2'b00, 0, 0, 0, 0, 32'hDEADBEEF, 0);

    step("t2_rst", rd(1, 0, 0, 0, 0), 2'b00, 0, 0, 0, 0, 0, 0);
    step("t2_both", rd(0, 1, 1, 1, 0), 2'b01, 1, 0, A0, 0, 0, 0);
    step("t2_m1", rd(0, 0, 1, 1, 32'h11111111), 2'b10, 1, 0, A1, 0, 32'h11111111, 0);
    step("t2_rsp", rd(0, 0, 0, 0, 32'h22222222), 2'b00, 0, 0, 0, 0, 0, 32'h22222222);

    step("t3_c1", rd(0, 0, 1, 0, 0), 2'b00, 1, 0, A1, 0, 0, 0);
    step("t3_c2", rd(0, 1, 1, 0, 0), 2'b00, 1, 0, A1, 0, 0, 0);
    step("t3_c3", rd(0, 1, 1, 0, 0), 2'b00, 1, 0, A1, 0, 0, 0);
    step("t3_acc", rd(0, 1, 1, 1, 0), 2'b10, 1, 0, A1, 0, 0, 0);
    step("t3_m0", rd(0, 1, 0, 1, 32'h33333333), 2'b01, 1, 0, A0, 0, 0, 32'h33333333);
    step("t3_rsp", rd(0, 0, 0, 0, 32'h44444444), 2'b00, 0, 0, 0, 0, 32'h44444444, 0);

    w = rd(0, 0, 0, 1, 0);
    w.m0we = 4'b0101; w.m0a = A0; w.m0d = 32'h11223344;
    step("t4_wr", w, 2'b01, 0, 4'b0101, A0, 32'h11223344, 0, 0);
    step("t4_none", rd(0, 0, 0, 0, 32'h55555555), 2'b00, 0, 0, 0, 0, 0, 0);

    // Continuous contention: fixed priority keeps m0, round-robin alternates.
    step("t5_rst", rd(1, 0, 0, 0, 0), 2'b00, 0, 0, 0, 0, 0, 0);
    pg = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef BOA_MEM_BUS_RR_EN
      g = k[0];
`else
      g = 1'b0;
`endif
      step($sformatf("t5_k%0d", k), rd(0, 1, 1, 1, 32'hA0000000 + k),
           g ? 2'b10 : 2'b01, 1, 0, g ? A1 : A0, 0,
           (k > 0 && !pg) ? 32'hA0000000 + k : 32'h0,
           (k > 0 &&  pg) ? 32'hA0000000 + k : 32'h0);
      pg = g;
    end
    step("t5_rsp", rd(0, 0, 0, 0, 32'hA0000004), 2'b00, 0, 0, 0, 0,
         pg ? 32'h0 : 32'hA0000004, pg ? 32'hA0000004 : 32'h0);

    step("t6_acc", rd(0, 1, 0, 1, 0), 2'b01, 1, 0, A0, 0, 0, 0);
    step("t6_rstrsp", rd(1, 0, 1, 1, 32'h77777777), 2'b00, 1, 0, A1, 0, 0, 0);
    step("t6_c1", rd(0, 0, 1, 0, 0), 2'b00, 1, 0, A1, 0, 0, 0);
    step("t6_c2", rd(0, 1, 1, 0, 0), 2'b00, 1, 0, A1, 0, 0, 0);
    step("t6_rst", rd(1, 1, 1, 1, 32'h66666666), 2'b00, 1, 0, A1, 0, 0, 0);
    step("t6_c4", rd(0, 1, 1, 1, 0), 2'b01, 1, 0, A0, 0, 0, 0);
    step("t6_rsp", rd(0, 0, 0, 0, 32'h88888888), 2'b00, 0, 0, 0, 0, 32'h88888888, 0);

    repeat (2) @(posedge clk);
    chk("drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
